mcp47feb_dac_writer: RTL and testbench

- Command sequencer placed directly upstream of the I2C master that drives the MCP47FEB DAC.
- Accepts a channel/12-bit code request on a valid/ready handshake.
- Drives the I2C master's command and data-in streams to write one volatile DAC register: address phase, 3 data bytes, stop.
- Reports completion and missed-ACK/timeout status so control logic no longer hand-sequences I2C transactions.

---
 rtl/mcp47feb_dac_writer_if.sv | 35 +++
 rtl/mcp47feb_dac_writer.sv | 167 ++++++++++++++++
 tb/tb_mcp47feb_dac_writer.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mcp47feb_dac_writer_if.sv
// Request/completion and I2C-master command/data streams of the MCP47FEB DAC writer.
// Every stream transfers on a clock edge where its valid and ready are both 1; valid and payload hold until then.
interface mcp47feb_dac_writer_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_channel;
    logic [11:0] req_value;
    logic        done;
    logic        err;
    logic [6:0]  cmd_address;
    logic        cmd_start;
    logic        cmd_write_multiple;
    logic        cmd_stop;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  data_in;
    logic        data_in_valid;
    logic        data_in_last;
    logic        data_in_ready;
    logic        i2c_busy;
    logic        i2c_missed_ack;
    logic [3:0]  fsm_state;

    modport master (
        input  req_valid, req_channel, req_value, cmd_ready, data_in_ready, i2c_busy, i2c_missed_ack,
        output req_ready, done, err, cmd_address, cmd_start, cmd_write_multiple, cmd_stop, cmd_valid,
               data_in, data_in_valid, data_in_last, fsm_state
    );

    modport slave (
        output req_valid, req_channel, req_value, cmd_ready, data_in_ready, i2c_busy, i2c_missed_ack,
        input  req_ready, done, err, cmd_address, cmd_start, cmd_write_multiple, cmd_stop, cmd_valid,
               data_in, data_in_valid, data_in_last, fsm_state
    );
endinterface

// File: rtl/mcp47feb_dac_writer.sv
// Sequences one volatile DAC register write (address, 3 bytes, stop) through an I2C master,
// reporting completion with a sticky missed-ACK/timeout error.
module mcp47feb_dac_writer #(
    parameter logic [6:0]  DEV_ADDR       = 7'b110_0000,
    parameter int unsigned STARTUP_CYCLES = 100000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input logic                   clk,
    input logic                   rst,
    mcp47feb_dac_writer_if.master bus
);
    typedef enum logic [3:0] {
        ST_STARTUP, ST_IDLE, ST_CMD, ST_B0, ST_B1, ST_B2, ST_WAIT_HI, ST_WAIT_LO, ST_FIN
    } state_t;

    typedef struct packed {
        logic       req_ready;
        logic       done;
        logic       err;
        logic       cmd_valid;
        logic       cmd_flags;
        logic [6:0] cmd_address;
        logic [7:0] data_in;
        logic       data_in_valid;
        logic       data_in_last;
    } out_t;

    state_t      state, state_n;
    out_t        out_q, out_n;
    logic [31:0] startup_cnt, startup_cnt_n;
    logic [31:0] timeout_cnt, timeout_cnt_n;
    logic        err_flag, err_flag_n;
    logic        chan_q, chan_n;
    logic [11:0] value_q, value_n;
    logic        active;

    assign active = state inside {ST_CMD, ST_B0, ST_B1, ST_B2, ST_WAIT_HI, ST_WAIT_LO};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_STARTUP;
            out_q       <= '0;
            startup_cnt <= '0;
            timeout_cnt <= '0;
            err_flag    <= 1'b0;
            chan_q      <= 1'b0;
            value_q     <= '0;
        end else begin
            state       <= state_n;
            out_q       <= out_n;
            startup_cnt <= startup_cnt_n;
            timeout_cnt <= timeout_cnt_n;
            err_flag    <= err_flag_n;
            chan_q      <= chan_n;
            value_q     <= value_n;
        end
    end

    always_comb begin
        state_n       = state;
        out_n         = out_q;
        out_n.done    = 1'b0;
        out_n.err     = 1'b0;
        startup_cnt_n = startup_cnt;
        timeout_cnt_n = timeout_cnt;
        err_flag_n    = err_flag;
        chan_n        = chan_q;
        value_n       = value_q;

        if (active) begin
            timeout_cnt_n = timeout_cnt + 32'd1;
            if (bus.i2c_missed_ack) err_flag_n = 1'b1;
        end

        case (state)
            ST_STARTUP: begin
                startup_cnt_n = startup_cnt + 32'd1;
                if (startup_cnt + 32'd1 >= STARTUP_CYCLES) state_n = ST_IDLE;
            end
            ST_IDLE: begin
                err_flag_n    = 1'b0;
                timeout_cnt_n = '0;
                if (bus.req_valid && out_q.req_ready) begin
                    chan_n            = bus.req_channel;
                    value_n           = bus.req_value;
                    out_n.req_ready   = 1'b0;
                    out_n.cmd_valid   = 1'b1;
                    out_n.cmd_flags   = 1'b1;
                    out_n.cmd_address = DEV_ADDR;
                    state_n           = ST_CMD;
                end else begin
                    out_n.req_ready = 1'b1;
                end
            end
            ST_CMD: begin
                if (out_q.cmd_valid && bus.cmd_ready) begin
                    out_n.cmd_valid   = 1'b0;
                    out_n.cmd_flags   = 1'b0;
                    out_n.cmd_address = '0;
                    state_n           = ST_B0;
                end
            end
            ST_B0: begin
                // First B0 cycle only loads the pointer byte; B1/B2 then follow with no bubble.
                if (!out_q.data_in_valid) begin
                    out_n.data_in_valid = 1'b1;
                    out_n.data_in       = {4'b0000, chan_q, 3'b000};
                end else if (bus.data_in_ready) begin
                    out_n.data_in = {4'b0000, value_q[11:8]};
                    state_n       = ST_B1;
                end
            end
            ST_B1: begin
                if (bus.data_in_ready) begin
                    out_n.data_in      = value_q[7:0];
                    out_n.data_in_last = 1'b1;
                    state_n            = ST_B2;
                end
            end
            ST_B2: begin
                if (bus.data_in_ready) begin
                    out_n.data_in       = '0;
                    out_n.data_in_valid = 1'b0;
                    out_n.data_in_last  = 1'b0;
                    state_n             = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: if (bus.i2c_busy) state_n = ST_WAIT_LO;
            ST_WAIT_LO: begin
                if (!bus.i2c_busy) begin
                    out_n.done = 1'b1;
                    out_n.err  = err_flag_n;
                    state_n    = ST_FIN;
                end
            end
            ST_FIN:  state_n = ST_IDLE;
            default: state_n = ST_STARTUP;
        endcase

        // Timeout abandons the streams mid-flight and reports through the normal done path.
        if (active && (timeout_cnt + 32'd1 >= TIMEOUT_CYCLES)) begin
            out_n.cmd_valid     = 1'b0;
            out_n.cmd_flags     = 1'b0;
            out_n.cmd_address   = '0;
            out_n.data_in       = '0;
            out_n.data_in_valid = 1'b0;
            out_n.data_in_last  = 1'b0;
            out_n.done          = 1'b1;
            out_n.err           = 1'b1;
            err_flag_n          = 1'b1;
            state_n             = ST_FIN;
        end
    end

    assign bus.req_ready          = out_q.req_ready;
    assign bus.done               = out_q.done;
    assign bus.err                = out_q.err;
    assign bus.cmd_valid          = out_q.cmd_valid;
    assign bus.cmd_start          = out_q.cmd_flags;
    assign bus.cmd_write_multiple = out_q.cmd_flags;
    assign bus.cmd_stop           = out_q.cmd_flags;
    assign bus.cmd_address        = out_q.cmd_address;
    assign bus.data_in            = out_q.data_in;
    assign bus.data_in_valid      = out_q.data_in_valid;
    assign bus.data_in_last       = out_q.data_in_last;
    assign bus.fsm_state          = state;
endmodule

// File: tb/tb_mcp47feb_dac_writer.sv
// Directed bench for mcp47feb_dac_writer: startup, byte stream content/timing, back-pressure,
// missed ACK, timeout and mid-transaction reset.
module tb_mcp47feb_dac_writer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mcp47feb_dac_writer_if bus ();

    mcp47feb_dac_writer #(
        .DEV_ADDR      (7'h60),
        .STARTUP_CYCLES(20),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [7:0] got_q[$];
    logic       last_q[$];
    int         hs_cyc, cmd_first_cyc, cmd_last_cyc, last_cyc, done_cyc;
    int         done_pulses, cmd_hs, data_hs, unstable;
    logic       err_val, cmd_valid_at_done, ready_after;
    logic [6:0] cmd_addr_seen;
    logic [2:0] cmd_flags_seen;

    function automatic logic [23:0] got_bytes();
        logic [23:0] v = '0;
        foreach (got_q[i]) if (i < 3) v[23-8*i -: 8] = got_q[i];
        return v;
    endfunction

    function automatic logic [2:0] got_lasts();
        logic [2:0] v = '0;
        foreach (last_q[i]) if (i < 3) v[2-i] = last_q[i];
        return v;
    endfunction

    function automatic logic [23:0] out_vec();
        return {bus.req_ready, bus.done, bus.err, bus.cmd_valid, bus.cmd_start, bus.cmd_write_multiple,
                bus.cmd_stop, bus.cmd_address, bus.data_in, bus.data_in_valid, bus.data_in_last};
    endfunction

    // Acts as the I2C master for one request; starts and ends at a sample point (#1 after posedge).
    task automatic drive_txn(input logic ch, input logic [11:0] val, input logic cmd_rdy,
                             input int rdy_period, input bit ack_in_b1, input int busy_len);
        int busy_left = 0;
        bit ack_done = 0;
        bit pend = 0;
        bit drdy;
        logic [7:0] pend_data = '0;
        hs_cyc = -1; cmd_first_cyc = -1; cmd_last_cyc = -1; last_cyc = -1; done_cyc = -1;
        done_pulses = 0; cmd_hs = 0; data_hs = 0; unstable = 0;
        err_val = 1'bx; cmd_valid_at_done = 1'bx; ready_after = 1'b0;
        cmd_addr_seen = '0; cmd_flags_seen = '0;
        got_q.delete(); last_q.delete();
        bus.req_channel = ch;
        bus.req_value   = val;
        bus.cmd_ready   = cmd_rdy;
        for (int cyc = 0; cyc < 400; cyc++) begin
            bus.i2c_busy = (busy_left > 0);
            if (busy_left > 0) busy_left--;
            bus.i2c_missed_ack = ack_in_b1 && !ack_done && bus.data_in_valid && (got_q.size() == 1);
            if (bus.i2c_missed_ack) ack_done = 1;
            bus.req_valid = (hs_cyc < 0);
            if (hs_cyc < 0 && bus.req_ready) hs_cyc = cyc;
            if (bus.cmd_valid) begin
                if (cmd_first_cyc < 0) begin
                    cmd_first_cyc  = cyc;
                    cmd_addr_seen  = bus.cmd_address;
                    cmd_flags_seen = {bus.cmd_start, bus.cmd_write_multiple, bus.cmd_stop};
                end
                cmd_last_cyc = cyc;
                if (bus.cmd_ready) cmd_hs++;
            end
            drdy = (cyc % rdy_period) == 0;
            bus.data_in_ready = drdy;
            if (bus.data_in_valid) begin
                if (pend && bus.data_in !== pend_data) unstable++;
                if (drdy) begin
                    got_q.push_back(bus.data_in);
                    last_q.push_back(bus.data_in_last);
                    data_hs++;
                    pend = 0;
                    if (bus.data_in_last) begin
                        last_cyc  = cyc;
                        busy_left = busy_len;
                    end
                end else begin
                    pend      = 1;
                    pend_data = bus.data_in;
                end
            end
            if (bus.done) begin
                done_pulses++;
                if (done_cyc < 0) begin
                    done_cyc          = cyc;
                    err_val           = bus.err;
                    cmd_valid_at_done = bus.cmd_valid;
                end
            end
            if (done_cyc >= 0 && cyc == done_cyc + 2) begin
                ready_after = bus.req_ready;
                break;
            end
            @(posedge clk);
            #1;
        end
        bus.req_valid      = 1'b0;
        bus.i2c_busy       = 1'b0;
        bus.i2c_missed_ack = 1'b0;
        bus.data_in_ready  = 1'b0;
        bus.cmd_ready      = 1'b1;
    endtask

    task automatic wait_startup(output int zeros);
        zeros = 0;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk);
            #1;
            if (bus.req_ready) break;
            zeros++;
        end
    endtask

    task automatic test_reset();
        int zeros;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (out_vec() !== 24'h0) begin
            n_err++; $display("FAIL reset_outputs: got %h expected 000000", out_vec());
        end
        n_cmp++;
        if (bus.fsm_state !== 4'd0) begin
            n_err++; $display("FAIL reset_state: got %0d expected 0", bus.fsm_state);
        end
        bus.req_valid = 1'b1; bus.req_channel = 1'b1; bus.req_value = 12'hABC;
        rst = 1'b0;
        wait_startup(zeros);
        n_cmp++;
        if (zeros !== 20) begin
            n_err++; $display("FAIL startup_ready_low: got %0d cycles expected 20", zeros);
        end
    endtask

    task automatic test_basic_write();
        drive_txn(1'b1, 12'hABC, 1'b1, 1, 1'b0, 10);
        n_cmp++;
        if (cmd_first_cyc - hs_cyc !== 1) begin
            n_err++; $display("FAIL basic_cmd_latency: got %0d expected 1", cmd_first_cyc - hs_cyc);
        end
        n_cmp++;
        if (cmd_addr_seen !== 7'h60) begin
            n_err++; $display("FAIL basic_cmd_address: got %h expected 60", cmd_addr_seen);
        end
        n_cmp++;
        if (cmd_flags_seen !== 3'b111) begin
            n_err++; $display("FAIL basic_cmd_flags: got %b expected 111", cmd_flags_seen);
        end
        n_cmp++;
        if (cmd_hs !== 1) begin
            n_err++; $display("FAIL basic_cmd_handshakes: got %0d expected 1", cmd_hs);
        end
        n_cmp++;
        if (got_bytes() !== 24'h080ABC || data_hs !== 3) begin
            n_err++; $display("FAIL basic_bytes: got %h (%0d) expected 080abc (3)", got_bytes(), data_hs);
        end
        n_cmp++;
        if (got_lasts() !== 3'b001) begin
            n_err++; $display("FAIL basic_last: got %b expected 001", got_lasts());
        end
        n_cmp++;
        if (last_cyc - hs_cyc !== 5) begin
            n_err++; $display("FAIL basic_last_latency: got %0d expected 5", last_cyc - hs_cyc);
        end
        n_cmp++;
        if (done_cyc - last_cyc !== 12) begin
            n_err++; $display("FAIL basic_done_timing: got %0d expected 12", done_cyc - last_cyc);
        end
        n_cmp++;
        if (err_val !== 1'b0) begin
            n_err++; $display("FAIL basic_err: got %b expected 0", err_val);
        end
        n_cmp++;
        if (done_pulses !== 1) begin
            n_err++; $display("FAIL basic_done_pulse: got %0d expected 1", done_pulses);
        end
        n_cmp++;
        if (ready_after !== 1'b1) begin
            n_err++; $display("FAIL basic_ready_after: got %b expected 1", ready_after);
        end
    endtask

    task automatic test_slow_ready();
        drive_txn(1'b0, 12'h001, 1'b1, 3, 1'b0, 3);
        n_cmp++;
        if (got_bytes() !== 24'h000001) begin
            n_err++; $display("FAIL slow_bytes: got %h expected 000001", got_bytes());
        end
        n_cmp++;
        if (got_lasts() !== 3'b001) begin
            n_err++; $display("FAIL slow_last: got %b expected 001", got_lasts());
        end
        n_cmp++;
        if (data_hs !== 3) begin
            n_err++; $display("FAIL slow_handshakes: got %0d expected 3", data_hs);
        end
        n_cmp++;
        if (unstable !== 0) begin
            n_err++; $display("FAIL slow_stable: got %0d changes expected 0", unstable);
        end
        n_cmp++;
        if (err_val !== 1'b0 || done_pulses !== 1) begin
            n_err++; $display("FAIL slow_done: got err=%b pulses=%0d expected err=0 pulses=1", err_val, done_pulses);
        end
    endtask

    task automatic test_missed_ack();
        drive_txn(1'b1, 12'h345, 1'b1, 1, 1'b1, 4);
        n_cmp++;
        if (got_bytes() !== 24'h080345 || data_hs !== 3) begin
            n_err++; $display("FAIL nack_bytes: got %h (%0d) expected 080345 (3)", got_bytes(), data_hs);
        end
        n_cmp++;
        if (err_val !== 1'b1 || done_pulses !== 1) begin
            n_err++; $display("FAIL nack_err: got err=%b pulses=%0d expected err=1 pulses=1", err_val, done_pulses);
        end
        drive_txn(1'b0, 12'h800, 1'b1, 1, 1'b0, 4);
        n_cmp++;
        if (got_bytes() !== 24'h000800) begin
            n_err++; $display("FAIL nack_next_bytes: got %h expected 000800", got_bytes());
        end
        n_cmp++;
        if (err_val !== 1'b0) begin
            n_err++; $display("FAIL nack_next_err: got %b expected 0", err_val);
        end
    endtask

    task automatic test_timeout();
        drive_txn(1'b1, 12'h123, 1'b0, 1, 1'b0, 0);
        n_cmp++;
        if (cmd_last_cyc - hs_cyc !== 50) begin
            n_err++; $display("FAIL timeout_cmd_hold: got %0d expected 50", cmd_last_cyc - hs_cyc);
        end
        n_cmp++;
        if (done_cyc - hs_cyc !== 51) begin
            n_err++; $display("FAIL timeout_done_timing: got %0d expected 51", done_cyc - hs_cyc);
        end
        n_cmp++;
        if (err_val !== 1'b1) begin
            n_err++; $display("FAIL timeout_err: got %b expected 1", err_val);
        end
        n_cmp++;
        if (cmd_valid_at_done !== 1'b0) begin
            n_err++; $display("FAIL timeout_cmd_drop: got %b expected 0", cmd_valid_at_done);
        end
        n_cmp++;
        if (data_hs !== 0 || cmd_hs !== 0) begin
            n_err++; $display("FAIL timeout_no_traffic: got data=%0d cmd=%0d expected 0/0", data_hs, cmd_hs);
        end
        n_cmp++;
        if (ready_after !== 1'b1) begin
            n_err++; $display("FAIL timeout_idle_resume: got %b expected 1", ready_after);
        end
    endtask

    task automatic test_reset_mid_txn();
        bit found = 0;
        int zeros;
        bus.cmd_ready = 1'b1; bus.data_in_ready = 1'b1;
        bus.req_valid = 1'b1; bus.req_channel = 1'b1; bus.req_value = 12'h5A7;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            bus.req_valid = 1'b0;
            if (bus.data_in_valid && bus.data_in === 8'h05) begin
                found = 1;
                break;
            end
        end
        n_cmp++;
        if (found !== 1'b1) begin
            n_err++; $display("FAIL midrst_reach_b1: got %b expected 1", found);
        end
        bus.data_in_ready = 1'b0;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (out_vec() !== 24'h0) begin
            n_err++; $display("FAIL midrst_outputs: got %h expected 000000", out_vec());
        end
        n_cmp++;
        if (bus.fsm_state !== 4'd0) begin
            n_err++; $display("FAIL midrst_state: got %0d expected 0", bus.fsm_state);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        wait_startup(zeros);
        n_cmp++;
        if (zeros !== 20) begin
            n_err++; $display("FAIL midrst_startup: got %0d cycles expected 20", zeros);
        end
        drive_txn(1'b0, 12'h3FF, 1'b1, 1, 1'b0, 5);
        n_cmp++;
        if (got_bytes() !== 24'h0003FF || got_lasts() !== 3'b001) begin
            n_err++; $display("FAIL midrst_next_bytes: got %h/%b expected 0003ff/001", got_bytes(), got_lasts());
        end
        n_cmp++;
        if (err_val !== 1'b0 || done_pulses !== 1) begin
            n_err++; $display("FAIL midrst_next_done: got err=%b pulses=%0d expected err=0 pulses=1", err_val, done_pulses);
        end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_channel = 1'b0; bus.req_value = '0;
        bus.cmd_ready = 1'b1; bus.data_in_ready = 1'b0;
        bus.i2c_busy = 1'b0; bus.i2c_missed_ack = 1'b0;
        test_reset();
        test_basic_write();
        test_slow_ready();
        test_missed_ack();
        test_timeout();
        test_reset_mid_txn();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within 200000 time units");
        $fatal(1);
    end
endmodule
